// File: rtl/urv_mem_responder.sv
// Shared instruction/data RAM responder for a uRV core. Define URV_MEM_CONSOLE_EN to map a
// 16-entry byte console FIFO at 0x0010_0000 (tx) and 0x0010_0004 (status).
module urv_mem_responder #(
   parameter int unsigned MEM_WORDS    = 4096,
   parameter int unsigned DM_LOAD_WAIT = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_store_done_o,
   output logic        dm_load_done_o,
   output logic        dm_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam logic [3:0] WaitInit = 4'(DM_LOAD_WAIT - 1);

   typedef enum logic [1:0] {StIdle, StLoadWait, StDone} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          status_q, status_d;
   logic          live_q;
   logic          store_done_q;
   logic [31:0]   im_data_q;
   logic [31:0]   load_data_q;

   logic [31:0]   mem [MEM_WORDS];

   logic [AW-1:0] im_idx, dm_idx, rd_idx;
   logic          store_acc, load_acc, ram_we, rd_en, rd_status;
   logic          cons_wr_sel, cons_rd_sel, cons_pend, cons_done;
   logic [1:0]    cons_status;

   assign im_idx = im_addr_i[AW+1:2];
   assign dm_idx = dm_addr_i[AW+1:2];

   // A console store parked on a full FIFO blocks all further requests.
   assign dm_ready_o = (state_q == StIdle) && live_q && !cons_pend;
   assign store_acc  = dm_ready_o && dm_store_i;
   assign load_acc   = dm_ready_o && dm_load_i && !dm_store_i;
   assign ram_we     = store_acc && !cons_wr_sel && rst_n_i;

   assign im_data_o       = im_data_q;
   assign im_valid_o      = live_q;
   assign dm_data_l_o     = load_data_q;
   assign dm_store_done_o = store_done_q;
   assign dm_load_done_o  = (state_q == StDone);

   logic unused_addr;
   assign unused_addr = ^{im_addr_i[31:AW+2], im_addr_i[1:0], dm_addr_i[31:AW+2], dm_addr_i[1:0]};

`ifdef URV_MEM_CONSOLE_EN
   localparam logic [31:0] ConsTxAddr   = 32'h0010_0000;
   localparam logic [31:0] ConsStatAddr = 32'h0010_0004;

   logic [7:0] fifo_q [16];
   logic [3:0] wr_ptr_q, rd_ptr_q;
   logic [4:0] count_q;
   logic       cons_pend_q;
   logic [7:0] pend_byte_q;
   logic       fifo_full, fifo_empty, cons_new, push, pop;
   logic [7:0] push_byte;

   assign cons_wr_sel = (dm_addr_i == ConsTxAddr);
   assign cons_rd_sel = (dm_addr_i == ConsStatAddr);
   assign fifo_full   = (count_q == 5'd16);
   assign fifo_empty  = (count_q == 5'd0);
   assign cons_status = {fifo_full, fifo_empty};
   assign cons_pend   = cons_pend_q;

   assign tx_valid_o = !fifo_empty;
   assign tx_data_o  = fifo_q[rd_ptr_q];
   assign pop        = tx_valid_o && tx_ready_i;

   assign cons_new  = store_acc && cons_wr_sel;
   assign push      = (cons_new || cons_pend_q) && !fifo_full;
   assign push_byte = cons_pend_q ? pend_byte_q : dm_data_s_i[7:0];
   assign cons_done = push;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cons_pend_q <= 1'b0;
         pend_byte_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
         count_q <= count_q + 5'(push) - 5'(pop);
         if (cons_new && fifo_full) begin
            cons_pend_q <= 1'b1;
            pend_byte_q <= dm_data_s_i[7:0];
         end else if (push) begin
            cons_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= push_byte;
   end
`else
   assign cons_wr_sel = 1'b0;
   assign cons_rd_sel = 1'b0;
   assign cons_status = 2'b00;
   assign cons_pend   = 1'b0;
   assign cons_done   = 1'b0;
   assign tx_valid_o  = 1'b0;
   assign tx_data_o   = 8'h00;

   logic unused_tx;
   assign unused_tx = tx_ready_i;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      status_d = status_q;
      rd_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_acc) begin
               addr_d   = dm_idx;
               status_d = cons_rd_sel;
               if (DM_LOAD_WAIT <= 1) begin
                  state_d = StDone;
                  rd_en   = 1'b1;
               end else begin
                  state_d = StLoadWait;
                  cnt_d   = WaitInit;
               end
            end
         end
         StLoadWait: begin
            if (cnt_q == 4'd1) begin
               state_d = StDone;
               rd_en   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Data is read on the edge entering StDone; a single-cycle wait reads the live address.
   assign rd_idx    = (state_q == StIdle) ? dm_idx : addr_q;
   assign rd_status = (state_q == StIdle) ? cons_rd_sel : status_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         addr_q       <= '0;
         status_q     <= 1'b0;
         live_q       <= 1'b0;
         store_done_q <= 1'b0;
         im_data_q    <= '0;
         load_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         status_q     <= status_d;
         live_q       <= 1'b1;
         store_done_q <= ram_we || cons_done;
         im_data_q    <= mem[im_idx];
         if (rd_en) begin
            load_data_q <= rd_status ? {30'b0, cons_status} : mem[rd_idx];
         end
      end
   end

   // RAM has no reset; reads above see the pre-write value on a same-cycle write.
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (dm_data_select_i[b]) mem[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/urv_mem_responder.md
URV_MEM_RESPONDER -- requirements
Module: urv_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, word count of the shared instruction/data RAM; power of two.
REQ-002 SHALL have parameter DM_LOAD_WAIT, default 1, cycles from load accept to load done; range 1..15.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_n_i, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port im_addr_i, input, 32, instruction byte address.
REQ-006 SHALL have port im_data_o, output, 32, instruction word.
REQ-007 SHALL have port im_valid_o, output, 1, im_data_o valid.
REQ-008 SHALL have port dm_addr_i, input, 32, data byte address.
REQ-009 SHALL have port dm_data_s_i, input, 32, store data.
REQ-010 SHALL have port dm_data_select_i, input, 4, store byte-lane enables.
REQ-011 SHALL have ports dm_store_i and dm_load_i, input, 1 each, request strobes.
REQ-012 SHALL have port dm_data_l_o, output, 32, load data.
REQ-013 SHALL have ports dm_store_done_o and dm_load_done_o, output, 1 each, completion pulses.
REQ-014 SHALL have port dm_ready_o, output, 1, responder idle and able to accept a request.
REQ-015 SHALL have ports tx_data_o (output, 8), tx_valid_o (output, 1) and tx_ready_i (input, 1), the console byte stream.

Function
REQ-016 SHALL return im_data_o = mem[im_addr_i[..:2] mod MEM_WORDS] registered on each clock, with im_valid_o = 1 on every cycle after the first post-reset edge.
REQ-017 SHALL implement the data FSM with states IDLE, LOAD_WAIT and DONE; dm_ready_o = 1 only in IDLE.
REQ-018 SHALL, in IDLE with dm_store_i = 1, write each byte lane whose dm_data_select_i bit is set on that edge and pulse dm_store_done_o for exactly one cycle on the next cycle, staying in IDLE.
REQ-019 SHALL, in IDLE with dm_load_i = 1, latch the address, enter LOAD_WAIT, and after DM_LOAD_WAIT cycles pulse dm_load_done_o for one cycle with dm_data_l_o valid during that cycle, then return to IDLE.
REQ-020 SHALL ignore requests while dm_ready_o = 0 and SHALL NOT queue them.
REQ-021 SHALL perform only the store when dm_store_i and dm_load_i are asserted together; the load is dropped and gives no done pulse.
REQ-022 SHALL return the newly stored value to a load accepted on the cycle after a store to the same word.
REQ-023 SHALL wrap word addresses modulo MEM_WORDS; no error indication.
REQ-024 SHALL hold dm_data_l_o after dm_load_done_o until the next load completes.
REQ-025 SHALL allow instruction fetch and data access to the same word in the same cycle; the fetch returns the pre-write value.

Reset
REQ-026 SHALL, while rst_n_i = 0 at a clock edge, force im_valid_o = 0, im_data_o = 0, dm_data_l_o = 0, both done pulses = 0, dm_ready_o = 0, tx_valid_o = 0 and the FSM to IDLE.
REQ-027 SHALL abort an in-flight load when reset is applied, with no dm_load_done_o pulse afterwards.
REQ-028 SHALL NOT modify RAM contents on reset.
REQ-029 SHALL assert dm_ready_o on the first edge after rst_n_i rises.

Configuration
REQ-030 SHALL compile in the console path when macro URV_MEM_CONSOLE_EN is defined. With the macro: a store to 0x0010_0000 pushes dm_data_s_i[7:0] into a 16-entry FIFO and does not write RAM. If the FIFO is full, dm_store_done_o is withheld and dm_ready_o = 0 until one entry drains. A load from 0x0010_0004 returns {30'b0, full, empty}. tx_valid_o = !empty, and a byte is popped when tx_valid_o and tx_ready_i are both 1. Reset flushes the FIFO.
REQ-031 SHALL, without URV_MEM_CONSOLE_EN, treat those addresses as ordinary RAM, tie tx_valid_o = 0 and tx_data_o = 0, and ignore tx_ready_i.

Verification
REQ-032 SHALL cover this scenario: preload mem[3] = 0xDEADBEEF, drive im_addr_i = 0x0C -> im_data_o = 0xDEADBEEF one cycle later with im_valid_o = 1.
REQ-033 SHALL cover this scenario: store 0x11223344 with select 4'b0101 at 0x20 over 0xFFFFFFFF, then load 0x20 with DM_LOAD_WAIT = 3 -> dm_load_done_o 3 cycles after accept, data 0xFF22FF44, dm_ready_o = 0 for those 3 cycles.
REQ-034 SHALL cover this scenario: dm_store_i and dm_load_i together at 0x40 -> only dm_store_done_o pulses; no dm_load_done_o within 20 cycles.
REQ-035 SHALL cover this scenario: load accepted, rst_n_i = 0 on the next cycle for 2 cycles -> no dm_load_done_o; dm_ready_o = 1 on the first edge after release.
REQ-036 SHALL cover this scenario (console enabled): 17 stores of 'A'..'Q' to 0x0010_0000 with tx_ready_i = 0 -> 17th store_done withheld and status load returns 0x2; setting tx_ready_i = 1 emits 'A' first and the 17th store completes.
REQ-037 SHALL cover this scenario: address 0x0000_4000 * 4 + 0x8 with MEM_WORDS = 4096 -> aliases to word 2 (wrap).
